sobel_frame_ctrl: RTL and testbench
===================================

// Module: sobel_frame_ctrl
// PURPOSE
//  Frame sequencer for the Sobel core. On Start it latches the threshold and arms the core.
//  It streams a full frame from image RAM into the core, one byte per consumed cycle.
//  It writes each edge bit and gradient to a result RAM, then signals Done (or Error on timeout).
//  Sits between the host/top level, image RAM, Sobel core and result RAM.
// PARAMETERS
//  IMG_W    256    frame width, pixels
//  IMG_H    256    frame height, pixels
//  ADDR_W   16     RAM address width, >= clog2(IMG_W*IMG_H)
//  WDOG     1024   max cycles allowed in DRAIN before Error
// PORTS
//  CLK           in   1       clock, rising edge
//  Reset_n       in   1       async reset, active low
//  Start         in   1       frame request, level, sampled in IDLE only
//  Abort         in   1       cancel frame, any state
//  Threshold     in   8       edge threshold, latched at Start
//  Busy          out  1       high in ARM/STREAM/DRAIN
//  Done          out  1       1-cycle pulse, frame complete
//  Error         out  1       sticky, watchdog expired; cleared by next accepted Start
//  Rd_Addr       out  ADDR_W  image RAM address
//  Rd_Data       in   8       image RAM data, 1-cycle read latency
//  Sobel_Start   out  1       core start, high ARM..DRAIN
//  Sobel_DataIn  out  8       = Rd_Data (combinational pass)
//  Sobel_Thresh  out  8       latched threshold
//  Sobel_State   in   2       core state; 1=LOAD, 2=PROC consume a pixel this cycle
//  Sobel_Ready   in   1       core isReady
//  Sobel_Finish  in   1       core Finish
//  Sobel_Dop     in   1       edge bit
//  Sobel_Grad    in   8       gradient
//  Wr_En         out  1       result write strobe
//  Wr_Addr       out  ADDR_W  result address
//  Wr_Edge       out  1       = Sobel_Dop
//  Wr_Grad       out  8       = Sobel_Grad
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, pix_cnt=out_cnt=wd_cnt=0, Error=0.
//  NPIX = IMG_W*IMG_H.
//  consume = Busy & (Sobel_State==1 | Sobel_State==2).
//  beat    = Busy & Sobel_Ready & ~Sobel_Finish & (Sobel_State==2).
//  FSM:
//   IDLE   : Start -> ARM; latch Threshold, clear counters and Error.
//   ARM    : 1 cycle; Rd_Addr=0 primes pixel 0 -> STREAM.
//   STREAM : pix_cnt += consume; leaves when pix_cnt reaches NPIX -> DRAIN.
//   DRAIN  : no reads; wd_cnt++ each cycle.
//            out_cnt==NPIX & Sobel_Finish -> DONE.
//            wd_cnt==WDOG-1 -> IDLE with Error=1.
//   DONE   : Done=1 for 1 cycle, Sobel_Start=0 -> IDLE.
//  Reads: Rd_Addr = pix_cnt + consume, saturating at NPIX-1.
//         This guarantees Rd_Data == pixel[pix_cnt] every cycle.
//         A core stall (no consume) holds the address, so the data is held.
//  Writes: Wr_En=beat, Wr_Addr=out_cnt; out_cnt += beat.
//          Beats beyond NPIX are dropped (no write).
//          Beats arrive in STREAM and DRAIN.
//  Counters are ADDR_W+1 bits wide; no wrap inside a frame.
//  Abort: any state -> IDLE next cycle; Sobel_Start=0, Wr_En=0, no Done, Error unchanged.
//  Start while Busy: ignored. Start held high after DONE: a new frame begins the cycle after IDLE.
//  Abort and Start in the same IDLE cycle: Abort wins.
//  Async reset mid-frame: immediate return to reset values; result RAM contents undefined.
// CONFIGURATION
//  SOBEL_EDGE_COUNT_EN defined:
//   adds output Edge_Count [ADDR_W:0], cleared at Start;
//   += (beat & Sobel_Dop & out_cnt<NPIX); valid from the Done pulse until the next Start.
//  Not defined: the port is absent and there is no counter logic.
// STRUCTURE
//  Package sobel_pkg: state enum (IDLE,ARM,STREAM,DRAIN,DONE) and core state codes.
//  The core state codes are SOBEL_ST_LOAD=2'd1 and SOBEL_ST_PROC=2'd2.
//  sobel_pkg also holds the NPIX localparam function.
//  One sub-module: sobel_wdog (loadable down-counter, expire pulse) used in DRAIN.
// TESTING
//  1. 4x4 frame, core model consumes every cycle from ARM+1:
//     Rd_Addr sequence is 0..15, 16 writes to addr 0..15, Done 1 cycle after the Finish cycle.
//  2. Core stalls 3 cycles at pixel 5:
//     Rd_Addr is held at 5, Sobel_DataIn is stable, no pixel is skipped or duplicated.
//  3. Core never asserts Finish, WDOG=8: Error=1 exactly 8 cycles after DRAIN entry, no Done.
//     The next Start clears Error.
//  4. Abort in STREAM at pix_cnt=7: next cycle IDLE, Sobel_Start=0, Wr_En=0, Done stays 0.
//  5. Reset_n pulsed low mid-DRAIN (async, between edges): outputs 0 immediately.
//     A later Start runs a clean frame.
//  6. SOBEL_EDGE_COUNT_EN, frame with 5 Dop=1 beats plus 2 extra beats past NPIX:
//     Edge_Count=5 at Done.

Source files
------------

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared types and constants for the Sobel frame sequencer:
//                sequencer state encoding, Sobel core state codes and the
//                frame pixel-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

   // Frame sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } sobel_state_t;

   // Sobel core state codes in which the core consumes one pixel.
   localparam logic [1:0] SOBEL_ST_LOAD = 2'd1;
   localparam logic [1:0] SOBEL_ST_PROC = 2'd2;

   // Number of pixels in a frame.
   function automatic int unsigned npix(input int unsigned w, input int unsigned h);
      return w * h;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_wdog
//  Description : Loadable down-counter watchdog. While i_load is high the
//                counter is preset to WDOG-1; while i_en is high it counts
//                down and o_expire pulses on the enabled cycle at zero, i.e.
//                on the WDOG-th enabled cycle after the load is released.
//  Ports       : i_clk    - clock, rising edge
//                i_rst_n  - asynchronous reset, active low
//                i_load   - preset the counter to WDOG-1
//                i_en     - count down one step per cycle
//                o_expire - high for the enabled cycle in which the count is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_wdog #(
   parameter int unsigned WDOG = 1024
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   localparam int unsigned CNT_W = (WDOG > 1) ? $clog2(WDOG) : 1;
   localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(WDOG - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= C_LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_expire = i_en & (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_frame_ctrl
//  Description : Frame sequencer for the Sobel core. On Start it latches the
//                threshold, arms the core, streams one frame from image RAM
//                (one byte per consumed cycle), writes every edge bit and
//                gradient to result RAM, then pulses Done, or raises the
//                sticky Error if the core fails to finish within WDOG cycles
//                of draining.
//  Config      : SOBEL_EDGE_COUNT_EN - adds the Edge_Count output, the number
//                of edge pixels written in the current frame.
//  Ports       : CLK, Reset_n             - clock / async active-low reset
//                Start, Abort, Threshold  - host control
//                Busy, Done, Error        - host status
//                Rd_Addr, Rd_Data         - image RAM (1-cycle read latency)
//                Sobel_*                  - Sobel core interface
//                Wr_En, Wr_Addr, Wr_Edge, Wr_Grad - result RAM write port
//                Edge_Count               - edge total (SOBEL_EDGE_COUNT_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned IMG_H  = 256,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WDOG   = 1024
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              Abort,
   input  logic [7:0]        Threshold,
   output logic              Busy,
   output logic              Done,
   output logic              Error,
   output logic [ADDR_W-1:0] Rd_Addr,
   input  logic [7:0]        Rd_Data,
   output logic              Sobel_Start,
   output logic [7:0]        Sobel_DataIn,
   output logic [7:0]        Sobel_Thresh,
   input  logic [1:0]        Sobel_State,
   input  logic              Sobel_Ready,
   input  logic              Sobel_Finish,
   input  logic              Sobel_Dop,
   input  logic [7:0]        Sobel_Grad,
   output logic              Wr_En,
   output logic [ADDR_W-1:0] Wr_Addr,
   output logic              Wr_Edge,
   output logic [7:0]        Wr_Grad
`ifdef SOBEL_EDGE_COUNT_EN
   ,
   output logic [ADDR_W:0]   Edge_Count
`endif
);

   // One spare bit so a counter can hold NPIX itself without wrapping.
   typedef logic [ADDR_W:0] cnt_t;

   localparam int unsigned NPIX = npix(IMG_W, IMG_H);
   localparam cnt_t C_NPIX    = cnt_t'(NPIX);
   localparam cnt_t C_NPIX_M1 = cnt_t'(NPIX - 1);
   localparam cnt_t C_ONE     = cnt_t'(1);

   sobel_state_t r_state;
   sobel_state_t w_next;

   cnt_t       r_pix_cnt;
   cnt_t       r_out_cnt;
   cnt_t       w_pix_next;
   cnt_t       w_rd_sat;
   logic [7:0] r_thresh;
   logic       r_error;

   logic w_busy;
   logic w_consume;
   logic w_beat;
   logic w_wr;
   logic w_start_acc;
   logic w_frame_done;
   logic w_wd_en;
   logic w_wd_expire;

   assign w_busy       = (r_state == ST_ARM) | (r_state == ST_STREAM) | (r_state == ST_DRAIN);
   assign w_consume    = w_busy & ((Sobel_State == SOBEL_ST_LOAD) | (Sobel_State == SOBEL_ST_PROC));
   assign w_beat       = w_busy & Sobel_Ready & ~Sobel_Finish & (Sobel_State == SOBEL_ST_PROC);
   assign w_wr         = w_beat & (r_out_cnt < C_NPIX);
   assign w_start_acc  = (r_state == ST_IDLE) & Start & ~Abort;
   assign w_frame_done = (r_out_cnt == C_NPIX) & Sobel_Finish;

   // Addressing one ahead on a consume cycle keeps Rd_Data equal to
   // pixel[pix_cnt] on every cycle despite the RAM latency; a stall holds
   // the address and therefore the data.
   assign w_pix_next = r_pix_cnt + (w_consume ? C_ONE : '0);
   assign w_rd_sat   = (w_pix_next > C_NPIX_M1) ? C_NPIX_M1 : w_pix_next;

   // ---------------------------------------------------------------- state
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (Start) w_next = ST_ARM;
         ST_ARM:    w_next = ST_STREAM;
         ST_STREAM: if (w_pix_next == C_NPIX) w_next = ST_DRAIN;
         ST_DRAIN: begin
            if (w_frame_done) begin
               w_next = ST_DONE;
            end else if (w_wd_expire) begin
               w_next = ST_IDLE;
            end
         end
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
      if (Abort) begin
         w_next = ST_IDLE;
      end
   end

   always_comb begin
      Busy        = w_busy;
      Sobel_Start = w_busy;
      Done        = 1'b0;
      Rd_Addr     = '0;
      w_wd_en     = 1'b0;
      case (r_state)
         ST_STREAM: Rd_Addr = ADDR_W'(w_rd_sat);
         ST_DRAIN:  w_wd_en = 1'b1;
         ST_DONE:   Done    = ~Abort;
         default:   ;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pix_cnt <= '0;
         r_out_cnt <= '0;
         r_thresh  <= '0;
         r_error   <= 1'b0;
      end else if (w_start_acc) begin
         r_pix_cnt <= '0;
         r_out_cnt <= '0;
         r_thresh  <= Threshold;
         r_error   <= 1'b0;
      end else begin
         if (r_state == ST_STREAM) begin
            r_pix_cnt <= w_pix_next;
         end
         if (w_wr) begin
            r_out_cnt <= r_out_cnt + C_ONE;
         end
         if ((r_state == ST_DRAIN) && w_wd_expire && !w_frame_done && !Abort) begin
            r_error <= 1'b1;
         end
      end
   end

   sobel_wdog #(
      .WDOG     (WDOG)
   ) u_wdog (
      .i_clk    (CLK),
      .i_rst_n  (Reset_n),
      .i_load   (~w_wd_en),
      .i_en     (w_wd_en),
      .o_expire (w_wd_expire)
   );

`ifdef SOBEL_EDGE_COUNT_EN
   cnt_t r_edge_cnt;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_edge_cnt <= '0;
      end else if (w_start_acc) begin
         r_edge_cnt <= '0;
      end else if (w_wr && Sobel_Dop) begin
         r_edge_cnt <= r_edge_cnt + C_ONE;
      end
   end

   assign Edge_Count = r_edge_cnt;
`endif

   assign Error        = r_error;
   assign Sobel_DataIn = Rd_Data;
   assign Sobel_Thresh = r_thresh;
   assign Wr_En        = w_wr;
   assign Wr_Addr      = ADDR_W'(r_out_cnt);
   assign Wr_Edge      = Sobel_Dop;
   assign Wr_Grad      = Sobel_Grad;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_frame_ctrl
//  Description : Directed self-checking bench for sobel_frame_ctrl on a 4x4
//                frame with an 8-cycle watchdog. Image RAM pixel i holds
//                8'h30+i; the scripted core produces beat k with gradient
//                8'h80+k and edge bit set for k = 0,2,4,6,8.
//  Config      : SOBEL_EDGE_COUNT_EN - also connects and checks Edge_Count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_frame_ctrl;
   import sobel_pkg::*;

   localparam int AW = 8;

   logic          CLK = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Start = 1'b0;
   logic          Abort = 1'b0;
   logic [7:0]    Threshold = '0;
   logic          Busy, Done, Error;
   logic [AW-1:0] Rd_Addr;
   logic [7:0]    Rd_Data = '0;
   logic          Sobel_Start;
   logic [7:0]    Sobel_DataIn, Sobel_Thresh;
   logic [1:0]    Sobel_State = '0;
   logic          Sobel_Ready = 1'b0;
   logic          Sobel_Finish = 1'b0;
   logic          Sobel_Dop = 1'b0;
   logic [7:0]    Sobel_Grad = '0;
   logic          Wr_En;
   logic [AW-1:0] Wr_Addr;
   logic          Wr_Edge;
   logic [7:0]    Wr_Grad;
`ifdef SOBEL_EDGE_COUNT_EN
   logic [AW:0]   Edge_Count;
`endif

   sobel_frame_ctrl #(
      .IMG_W(4), .IMG_H(4), .ADDR_W(AW), .WDOG(8)
   ) dut (
      .CLK          (CLK),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .Abort        (Abort),
      .Threshold    (Threshold),
      .Busy         (Busy),
      .Done         (Done),
      .Error        (Error),
      .Rd_Addr      (Rd_Addr),
      .Rd_Data      (Rd_Data),
      .Sobel_Start  (Sobel_Start),
      .Sobel_DataIn (Sobel_DataIn),
      .Sobel_Thresh (Sobel_Thresh),
      .Sobel_State  (Sobel_State),
      .Sobel_Ready  (Sobel_Ready),
      .Sobel_Finish (Sobel_Finish),
      .Sobel_Dop    (Sobel_Dop),
      .Sobel_Grad   (Sobel_Grad),
      .Wr_En        (Wr_En),
      .Wr_Addr      (Wr_Addr),
      .Wr_Edge      (Wr_Edge),
      .Wr_Grad      (Wr_Grad)
`ifdef SOBEL_EDGE_COUNT_EN
      ,
      .Edge_Count   (Edge_Count)
`endif
   );

   always #5 CLK = ~CLK;

   // Image RAM with one cycle of read latency.
   logic [7:0] img [0:255];
   always @(posedge CLK) Rd_Data <= img[Rd_Addr];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Values sampled at the negedge of the last cycle, plus captured writes.
   logic          s_busy, s_start, s_done, s_err, s_wren;
   logic [AW-1:0] s_rd, s_wr_addr;
   logic [7:0]    s_din, s_thresh;
   logic [31:0]   s_edge;
   int            n_done;
   int            wr_n;
   logic [AW-1:0] wr_addr_a [0:31];
   logic [7:0]    wr_grad_a [0:31];
   logic          wr_edge_a [0:31];

   function automatic logic dop_of(input int k);
      return (k < 10) && (k % 2 == 0);
   endfunction

   // One clock cycle: drive core inputs at posedge+1, sample at negedge.
   task automatic cyc(input logic [1:0] st, input logic rdy, input logic fin,
                      input logic dop, input logic [7:0] grad);
      Sobel_State  = st;
      Sobel_Ready  = rdy;
      Sobel_Finish = fin;
      Sobel_Dop    = dop;
      Sobel_Grad   = grad;
      @(negedge CLK);
      s_busy    = Busy;
      s_start   = Sobel_Start;
      s_done    = Done;
      s_err     = Error;
      s_wren    = Wr_En;
      s_rd      = Rd_Addr;
      s_wr_addr = Wr_Addr;
      s_din     = Sobel_DataIn;
      s_thresh  = Sobel_Thresh;
`ifdef SOBEL_EDGE_COUNT_EN
      s_edge    = 32'(Edge_Count);
`else
      s_edge    = '0;
`endif
      if (Done) n_done++;
      if (Wr_En && wr_n < 32) begin
         wr_addr_a[wr_n] = Wr_Addr;
         wr_grad_a[wr_n] = Wr_Grad;
         wr_edge_a[wr_n] = Wr_Edge;
         wr_n++;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"},   32'(Busy), 0);
      chk({tag, "_start"},  32'(Sobel_Start), 0);
      chk({tag, "_done"},   32'(Done), 0);
      chk({tag, "_err"},    32'(Error), 0);
      chk({tag, "_wren"},   32'(Wr_En), 0);
      chk({tag, "_rdaddr"}, 32'(Rd_Addr), 0);
      chk({tag, "_wraddr"}, 32'(Wr_Addr), 0);
      chk({tag, "_thresh"}, 32'(Sobel_Thresh), 0);
   endtask

   // mode: 0 = core finishes, 1 = core never finishes (watchdog),
   //       2 = async reset in DRAIN, 3 = abort at pix_cnt 7.
   task automatic run_frame(input int stall_pix, input int extra, input int mode,
                            input logic hold, input logic [7:0] thr);
      int k;
      int nd;
      logic lo;
      k      = 0;
      nd     = 0;
      wr_n   = 0;
      n_done = 0;
      Threshold = thr;
      Start = 1'b1;
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);          // IDLE, Start accepted
      chk("idle_busy", 32'(s_busy), 0);
      Start = hold;
      Threshold = ~thr;                             // must not be re-latched
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);          // ARM
      chk("arm_busy", 32'(s_busy), 1);
      chk("arm_sobel_start", 32'(s_start), 1);
      chk("arm_rdaddr", 32'(s_rd), 0);
      chk("arm_err", 32'(s_err), 0);
      chk("arm_thresh", 32'(s_thresh), 32'(thr));
      for (int p = 0; p < 16; p++) begin
         if (p == stall_pix) begin
            repeat (3) begin
               cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
               chk("stall_rdaddr", 32'(s_rd), 32'(p));
               chk("stall_din", 32'(s_din), 32'(8'h30 + p));
               chk("stall_wren", 32'(s_wren), 0);
            end
         end
         if (mode == 3 && p == 7) begin
            Abort = 1'b1;
            cyc(SOBEL_ST_PROC, 1'b1, 1'b0, dop_of(k), 8'h80 + 8'(k));
            Abort = 1'b0;
            cyc(SOBEL_ST_PROC, 1'b1, 1'b0, dop_of(k + 1), 8'h81 + 8'(k));
            chk("abort_busy", 32'(s_busy), 0);
            chk("abort_sobel_start", 32'(s_start), 0);
            chk("abort_wren", 32'(s_wren), 0);
            cyc(SOBEL_ST_PROC, 1'b1, 1'b1, 1'b0, 8'h00);
            chk("abort_still_idle", 32'(s_busy), 0);
            chk("abort_no_done", n_done, 0);
            return;
         end
         lo = (p < 2);
         cyc(lo ? SOBEL_ST_LOAD : SOBEL_ST_PROC, !lo, 1'b0,
             lo ? 1'b0 : dop_of(k), lo ? 8'h00 : 8'h80 + 8'(k));
         if (!lo) k++;
         chk("stream_din", 32'(s_din), 32'(8'h30 + p));
         chk("stream_rdaddr", 32'(s_rd), (p < 15) ? 32'(p + 1) : 32'd15);
         chk("stream_busy", 32'(s_busy), 1);
      end
      // DRAIN: remaining beats, then any surplus beats past the frame.
      while (k < 16 + extra) begin
         cyc(SOBEL_ST_PROC, 1'b1, 1'b0, dop_of(k), 8'h80 + 8'(k));
         chk("drain_wren", 32'(s_wren), (k < 16) ? 32'd1 : 32'd0);
         chk("drain_busy", 32'(s_busy), 1);
         k++;
         nd++;
      end
      case (mode)
         0: begin
            cyc(SOBEL_ST_PROC, 1'b1, 1'b1, 1'b0, 8'h00);   // Finish cycle
            chk("fin_done", 32'(s_done), 0);
            chk("fin_wren", 32'(s_wren), 0);
            cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);            // DONE
            chk("done_pulse", 32'(s_done), 1);
            chk("done_busy", 32'(s_busy), 0);
            chk("done_sobel_start", 32'(s_start), 0);
`ifdef SOBEL_EDGE_COUNT_EN
            chk("edge_count", s_edge, 5);
`endif
            chk("done_count", n_done, 1);
            chk("wr_count", wr_n, 16);
            for (int i = 0; i < 16 && i < wr_n; i++) begin
               chk("wr_addr", 32'(wr_addr_a[i]), 32'(i));
               chk("wr_grad", 32'(wr_grad_a[i]), 32'(8'h80 + i));
               chk("wr_edge", 32'(wr_edge_a[i]), 32'(dop_of(i)));
            end
         end
         1: begin
            while (nd < 8) begin
               cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
               chk("wdog_busy", 32'(s_busy), 1);
               chk("wdog_err_early", 32'(s_err), 0);
               nd++;
            end
            cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
            chk("wdog_idle", 32'(s_busy), 0);
            chk("wdog_err", 32'(s_err), 1);
            chk("wdog_no_done", n_done, 0);
         end
         2: begin
            #2 Reset_n = 1'b0;
            #1 chk_reset_outputs("async_rst");
            @(negedge CLK);
            Reset_n = 1'b1;
            @(posedge CLK);
            #1;
         end
         default: ;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) img[i] = (i < 16) ? 8'(8'h30 + i) : 8'hEE;

      repeat (2) @(posedge CLK);
      #1 chk_reset_outputs("por");
      Reset_n = 1'b1;
      @(posedge CLK);
      #1;

      // Plain frame.
      run_frame(-1, 0, 0, 1'b0, 8'h5A);

      // Stall at pixel 5, Start held high throughout.
      run_frame(5, 0, 0, 1'b1, 8'hC3);
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("restart_idle", 32'(s_busy), 0);
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("restart_arm", 32'(s_busy), 1);
      Start = 1'b0;
      Abort = 1'b1;
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      Abort = 1'b0;
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("restart_abort", 32'(s_busy), 0);

      // Watchdog expiry, Error sticky until the next accepted Start.
      run_frame(-1, 0, 1, 1'b0, 8'h11);
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("err_sticky", 32'(s_err), 1);
      run_frame(-1, 0, 0, 1'b0, 8'h22);

      // Abort mid-stream.
      run_frame(-1, 0, 3, 1'b0, 8'h33);

      // Asynchronous reset in DRAIN, then a clean frame.
      run_frame(-1, 0, 2, 1'b0, 8'h44);
      run_frame(-1, 0, 0, 1'b0, 8'h55);

      // Two surplus beats past the end of the frame are dropped.
      run_frame(-1, 2, 0, 1'b0, 8'h66);

      // Abort and Start together in IDLE: Abort wins.
      Start = 1'b1;
      Abort = 1'b1;
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      Start = 1'b0;
      Abort = 1'b0;
      cyc(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("abort_start_same", 32'(s_busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
